// File: rtl/uart_tx_feeder_if.sv
// Byte-source valid/ready handshake plus the transmitter launch handshake used by uart_tx_feeder.
interface uart_tx_feeder_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;

   // master: the feeder; slave: the byte source and transmitter side
   modport master (
      input  s_valid, s_data, tx_done,
      output s_ready, tx_start, tx_data
   );
   modport slave (
      output s_valid, s_data, tx_done,
      input  s_ready, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// FIFO-buffered launcher for a UART transmitter's tx_start/tx_data/tx_done handshake.
// Optional FIFO flush input is enabled by defining UART_TXF_FLUSH_EN.
module uart_tx_feeder #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
`ifdef UART_TXF_FLUSH_EN
   input  logic              flush,
`endif
   uart_tx_feeder_if.master  bus,
   output logic [ADDR_W:0]   fifo_count,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              busy
);
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

   state_t             state;
   logic [7:0]         mem [DEPTH];
   logic [ADDR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0]  rd_ptr;
   logic               flush_c;
   logic               ready_c;
   logic               push_c;
   logic               pop_c;
   logic [CNT_W-1:0]   count_nxt;

`ifdef UART_TXF_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   assign ready_c     = !fifo_full && !flush_c;
   assign bus.s_ready = ready_c;

   // Push/pop qualification; a flush discards both the incoming byte and any IDLE launch
   always_comb begin
      push_c    = 1'b0;
      pop_c     = 1'b0;
      count_nxt = fifo_count;
      push_c = bus.s_valid && ready_c;
      pop_c  = (state == IDLE) && !fifo_empty && bus.tx_done && !flush_c;
      if (flush_c)
         count_nxt = '0;
      else
         count_nxt = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   // FIFO pointers and registered occupancy flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
      end else begin
         if (flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_c)
               wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_c)
               rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         fifo_count <= count_nxt;
         fifo_empty <= (count_nxt == '0);
         fifo_full  <= (count_nxt == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push_c)
         mem[wr_ptr] <= bus.s_data;
   end

   // Launch FSM; busy mirrors the post-edge state and occupancy
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= 8'h00;
         busy         <= 1'b0;
      end else begin
         bus.tx_start <= 1'b0;
         busy <= (count_nxt != '0) ||
                 ((state == IDLE) ? pop_c : !((state == WAIT_DONE) && bus.tx_done));
         case (state)
            IDLE: begin
               if (pop_c) begin
                  state        <= LAUNCH;
                  bus.tx_start <= 1'b1;
                  bus.tx_data  <= mem[rd_ptr];
               end
            end
            LAUNCH:    state <= WAIT_ACK;
            WAIT_ACK:  if (!bus.tx_done) state <= WAIT_DONE;
            WAIT_DONE: if (bus.tx_done)  state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized scoreboard bench for uart_tx_feeder with a behavioural transmitter model.
module tb_uart_tx_feeder;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W:0]   fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              busy;
`ifdef UART_TXF_FLUSH_EN
   logic              flush = 1'b0;
`endif

   uart_tx_feeder_if bus();

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
`ifdef UART_TXF_FLUSH_EN
      .flush      (flush),
`endif
      .bus        (bus),
      .fifo_count (fifo_count),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .busy       (busy)
   );

   initial forever #5 clk = ~clk;

   // Reference model: bytes accepted but not yet launched, plus transmitter timing
   logic [7:0] q[$];
   logic [7:0] last_tx_data = 8'h00;
   bit         prev_start = 1'b0;
   bit         hold_low = 1'b0;
   int         frame_len = 4;
   int         xmit_cnt = 0;
   int         n_launch = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sample after the edge, score launches, advance the transmitter model
   task automatic observe();
      @(negedge clk);
      if (bus.tx_start) begin
         check("start_width", 32'(prev_start), 0);
         check("start_when_done", 32'(bus.tx_done), 1);
         check("launch_nonempty", 32'(q.size() > 0), 1);
         if (q.size() > 0)
            check("tx_data_order", 32'(bus.tx_data), 32'(q.pop_front()));
         last_tx_data = bus.tx_data;
         n_launch++;
         bus.tx_done = 1'b0;
         xmit_cnt = frame_len;
      end else begin
         check("tx_data_hold", 32'(bus.tx_data), 32'(last_tx_data));
         if (!bus.tx_done && !hold_low && xmit_cnt > 0) begin
            xmit_cnt--;
            if (xmit_cnt == 0)
               bus.tx_done = 1'b1;
         end
      end
      prev_start = bus.tx_start;
      check("count", 32'(fifo_count), q.size());
      check("empty", 32'(fifo_empty), 32'(q.size() == 0));
      check("full", 32'(fifo_full), 32'(q.size() == DEPTH));
      if (q.size() > 0)
         check("busy_nonempty", 32'(busy), 1);
   endtask

   task automatic push_cycle(input bit valid, input logic [7:0] data);
      check("s_ready", 32'(bus.s_ready), 32'(q.size() < DEPTH));
      bus.s_valid = valid;
      bus.s_data  = data;
      if (valid && q.size() < DEPTH)
         q.push_back(data);
      observe();
      bus.s_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.s_valid = 1'b0;
      q.delete();
      last_tx_data = 8'h00;
      observe();
      reset_n = 1'b1;
      check("rst_tx_start", 32'(bus.tx_start), 0);
      check("rst_tx_data", 32'(bus.tx_data), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_s_ready", 32'(bus.s_ready), 1);
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((q.size() > 0 || !bus.tx_done) && n < max_cyc) begin
         push_cycle(1'b0, 8'h00);
         n++;
      end
      check("drain_timeout", 32'(n < max_cyc), 1);
      push_cycle(1'b0, 8'h00);
      push_cycle(1'b0, 8'h00);
      check("busy_idle", 32'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n0;
      int         sent;
      int         guard;
      bit         v;
      logic [7:0] d;

      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.tx_done = 1'b1;
      do_reset();
      check("rst_empty", 32'(fifo_empty), 1);
      check("rst_full", 32'(fifo_full), 0);

      // Single byte latency: pushed at E0, tx_start visible after E1 for one cycle
      frame_len = 4;
      push_cycle(1'b1, 8'hA5);
      check("t1_e0_start", 32'(bus.tx_start), 0);
      check("t1_e0_count", 32'(fifo_count), 1);
      push_cycle(1'b0, 8'h00);
      check("t1_e1_start", 32'(bus.tx_start), 1);
      check("t1_e1_data", 32'(bus.tx_data), 32'h0000_00A5);
      check("t1_e1_count", 32'(fifo_count), 0);
      push_cycle(1'b0, 8'h00);
      check("t1_e2_start", 32'(bus.tx_start), 0);
      drain(200);

      // Fill to DEPTH with the transmitter busy; the 17th byte is refused
      hold_low = 1'b1;
      bus.tx_done = 1'b0;
      for (int i = 1; i <= 17; i++)
         push_cycle(1'b1, 8'(i));
      check("t2_count", 32'(fifo_count), 16);
      check("t2_full", 32'(fifo_full), 1);
      check("t2_s_ready", 32'(bus.s_ready), 0);
      hold_low = 1'b0;
      xmit_cnt = 1;
      drain(1000);

      // Long frames: exactly three launches in order
      frame_len = 160;
      n0 = n_launch;
      push_cycle(1'b1, 8'h55);
      push_cycle(1'b1, 8'hAA);
      push_cycle(1'b1, 8'h0F);
      drain(1000);
      check("t3_launches", 32'(n_launch - n0), 3);

      // Push coinciding with a launch pop keeps the count at 5
      frame_len = 4;
      hold_low = 1'b1;
      bus.tx_done = 1'b0;
      for (int i = 0; i < 5; i++)
         push_cycle(1'b1, 8'($urandom));
      hold_low = 1'b0;
      bus.tx_done = 1'b1;
      push_cycle(1'b1, 8'($urandom));
      check("t4_launch", 32'(bus.tx_start), 1);
      check("t4_count_same", 32'(fifo_count), 5);
      drain(500);

      // Random stream of 40 bytes with random gaps and frame lengths
      sent = 0;
      guard = 0;
      while (sent < 40 && guard < 4000) begin
         v = ($urandom_range(0, 3) != 0);
         d = 8'($urandom);
         frame_len = $urandom_range(2, 6);
         if (v && q.size() < DEPTH)
            sent++;
         push_cycle(v, d);
         guard++;
      end
      check("t4_stream_bound", 32'(sent), 40);
      drain(2000);

      // Reset during a frame with three bytes queued
      frame_len = 40;
      push_cycle(1'b1, 8'h31);
      push_cycle(1'b0, 8'h00);
      check("t5_launch", 32'(bus.tx_start), 1);
      push_cycle(1'b1, 8'h32);
      push_cycle(1'b1, 8'h33);
      push_cycle(1'b1, 8'h34);
      for (int i = 0; i < 5; i++)
         push_cycle(1'b0, 8'h00);
      check("t5_pre_count", 32'(fifo_count), 3);
      do_reset();
      n0 = n_launch;
      push_cycle(1'b1, 8'h35);
      for (int i = 0; i < 3; i++)
         push_cycle(1'b0, 8'h00);
      check("t5_no_launch", 32'(n_launch - n0), 0);
      check("t5_refill_count", 32'(fifo_count), 1);
      drain(500);
      check("t5_late_launch", 32'(n_launch - n0), 1);

`ifdef UART_TXF_FLUSH_EN
      // Flush with a simultaneous push while a frame is in flight
      frame_len = 40;
      push_cycle(1'b1, 8'h41);
      push_cycle(1'b0, 8'h00);
      for (int i = 0; i < 7; i++)
         push_cycle(1'b1, 8'(8'h50 + i));
      push_cycle(1'b0, 8'h00);
      check("t6_pre_count", 32'(fifo_count), 7);
      flush = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hEE;
      #1;
      check("t6_s_ready", 32'(bus.s_ready), 0);
      q.delete();
      observe();
      flush = 1'b0;
      bus.s_valid = 1'b0;
      check("t6_count", 32'(fifo_count), 0);
      n0 = n_launch;
      drain(500);
      check("t6_no_launch", 32'(n_launch - n0), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
